aud_tx_sched: RTL and testbench
===============================

# aud_tx_sched

Frame scheduler for the WM8978 DAC path. It generates `aud_bclk`/`aud_lrc` from the system clock and accepts stereo sample pairs from upstream over a valid/ready handshake. It presents each channel word on `dac_data` to the serial sender well before that sender latches it on the `aud_lrc` edge, and counts underruns. It sits between the noise-cancellation sample pipeline and the bit serializer.

## Interface
- `CLK_DIV`, 4: `sys_clk` cycles per half period of `aud_bclk`. Legal values are ≥2.
- `SLOT_BITS`, 32: `aud_bclk` periods per channel slot. Must be even, in the range 18..32.
- `WL`, 16: sample word length. Fixed at 16 in this design.
- `sys_clk` in 1: system clock. This is the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: run enable.
- `mute` in 1: forces `dac_data` to 0. Samples are still consumed.
- `s_valid` in 1: upstream pair valid.
- `s_ready` out 1: the pending register is empty.
- `s_left` in 16: left sample, two's complement.
- `s_right` in 16: right sample, two's complement.
- `aud_bclk` out 1: bit clock to the WM8978 and the serializer.
- `aud_lrc` out 1: channel clock. 0 = left, 1 = right.
- `dac_data` out 16: word for the serializer.
- `underrun` out 1: one-cycle pulse when a frame load finds no data.
- `underrun_cnt` out 16: saturating underrun count.

## Operation
- Divider:
  - `div_cnt` counts 0..CLK_DIV-1.
  - At CLK_DIV-1 it wraps and `aud_bclk` toggles.
  - A toggle from 1 to 0 is a "fall event".
- Bit index:
  - `bit_idx` is 0..2*SLOT_BITS-1. It increments on each fall event and wraps to 0.
  - `aud_lrc` = (`bit_idx` ≥ SLOT_BITS). It is registered and changes on the same fall event as `bit_idx`.
- Storage:
  - Pending register (one pair plus a full flag).
  - Current register (one pair).
  - `s_ready` = !pend_full, driven combinationally.
  - Accept when `s_valid && s_ready`: write the pair into pending and set pend_full.
- Right-word stage, on the fall event where `bit_idx` becomes SLOT_BITS/2: `dac_data` <= current right (0 if `mute`).
- Frame load, on the fall event where `bit_idx` becomes SLOT_BITS+SLOT_BITS/2:
  - If pend_full: current <= pending, clear pend_full, `dac_data` <= new left.
  - Else if `s_valid` in the same cycle (bypass): current <= `s_left`/`s_right` directly, the handshake completes, pending stays empty, no underrun.
  - Else: current <= 0, `dac_data` <= 0, `underrun` pulses for 1 cycle, `underrun_cnt` increments. The count saturates at 16'hFFFF.
- Accept and load in the same cycle with pend_full=1: the load empties pending. `s_ready` was 0, so no accept happens. `s_ready` rises the next cycle.
- `mute`:
  - Sampled only at the two dac_data update points.
  - Storage, handshake and underrun counting are unaffected.
- `en`=0:
  - `div_cnt`, `bit_idx`, `aud_bclk` and `aud_lrc` are held at 0.
  - `dac_data` holds its value. No loads and no underruns occur.
  - Upstream may still fill pending.
- `en` rising: counting starts from `div_cnt`=0 and `bit_idx`=0.
  - The first left slot carries the held `dac_data`.
  - The first frame load happens at `bit_idx` SLOT_BITS+SLOT_BITS/2.

## Timing
- Reset (while `rst`=1 and after it is released):
  - `aud_bclk`, `aud_lrc`, `underrun` are 0.
  - `dac_data`, `underrun_cnt` are 16'h0.
  - pend_full is 0, so `s_ready` is 1.
  - `rst` asserted mid-frame drops all state immediately, including an unconsumed pending pair.
- Rates:
  - `aud_bclk` period = 2*CLK_DIV `sys_clk` cycles.
  - Frame = 2*SLOT_BITS*2*CLK_DIV cycles; 512 cycles at the defaults.
- Setup margin: `dac_data` changes SLOT_BITS/2 bclk periods before the `aud_lrc` edge. The serializer latches on the first bclk rise after the edge, so `dac_data` is stable for ≥ SLOT_BITS/2 bclk periods around the latch.
- Handshake latency:
  - An accepted pair reaches `dac_data` (left) at the next frame-load event.
  - Right follows SLOT_BITS bclk periods later.
- `underrun` is a pulse in the same cycle as the failed load event. `underrun_cnt` updates in that cycle too.

## Test plan
- Reset and default parameters, `en`=1, no `s_valid`:
  - `aud_bclk` period is 8 cycles; `aud_lrc` period is 512 cycles.
  - The first `underrun` pulse occurs 48 bclk periods after `en`; `underrun_cnt` = 1.
  - Then +1 per frame and `dac_data` = 0.
- Load pairs (L=16'h1234, R=16'hABCD), then (16'h8000, 16'h7FFF), with `s_valid` held:
  - `dac_data` shows 1234 during the right half before the left slot, and ABCD during the left half before the right slot.
  - The second pair appears one frame later.
  - `s_ready` deasserts while pending is full.
  - No underruns.
- Bypass: keep pending empty and assert `s_valid` exactly on the load-event cycle:
  - The pair is loaded directly; `underrun` stays 0; `s_ready` stays 1.
- `mute`=1 with continuous data:
  - `dac_data` = 0 at both update points.
  - `s_ready` handshakes continue at one pair per frame.
  - `underrun_cnt` is unchanged.
- Pulse `rst` mid-frame with a pending pair:
  - All outputs return to reset values immediately and `s_ready` = 1.
  - After release, the pending pair is lost.
- `en` deasserted mid-frame:
  - `aud_bclk` and `aud_lrc` go to 0 and `dac_data` holds.
  - On re-enable the frame restarts at `bit_idx` 0.
- Force 65 536 underruns by preloading the counter: it saturates at 16'hFFFF.

Source files
------------

// File: rtl/aud_tx_sched_if.sv
// Upstream stereo-pair handshake between the sample pipeline and the frame scheduler.
interface aud_tx_sched_if #(
  parameter int WL = 16
);
  logic                 s_valid;
  logic                 s_ready;
  logic signed [WL-1:0] s_left;
  logic signed [WL-1:0] s_right;

  modport master (output s_valid, output s_left, output s_right, input s_ready);
  modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/aud_tx_sched.sv
// WM8978 DAC frame scheduler: derives aud_bclk/aud_lrc from sys_clk, holds one
// pending and one current stereo pair, and stages each channel word on dac_data
// half a slot ahead of the aud_lrc edge the serializer latches on.
module aud_tx_sched #(
  parameter int CLK_DIV   = 4,
  parameter int SLOT_BITS = 32,
  parameter int WL        = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mute,
  aud_tx_sched_if.slave        s,
  output logic                 aud_bclk,
  output logic                 aud_lrc,
  output logic signed [WL-1:0] dac_data,
  output logic                 underrun,
  output logic [15:0]          underrun_cnt
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_IDX  = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] RIGHT_IDX = BIT_W'(SLOT_BITS / 2);
  localparam logic [BIT_W-1:0] LOAD_IDX  = BIT_W'(SLOT_BITS + SLOT_BITS / 2);

  // Word presented to the serializer, zeroed while muted.
  function automatic logic signed [WL-1:0] mute_word(input logic signed [WL-1:0] w,
                                                     input logic m);
    return m ? '0 : w;
  endfunction

  // Saturating increment for the underrun counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 bclk_q, bclk_d;
  logic                 lrc_q, lrc_d;
  logic                 pend_full_q, pend_full_d;
  logic signed [WL-1:0] pend_l_q, pend_l_d;
  logic signed [WL-1:0] pend_r_q, pend_r_d;
  logic signed [WL-1:0] cur_r_q, cur_r_d;
  logic signed [WL-1:0] dac_q, dac_d;
  logic                 underrun_q, underrun_d;
  logic [15:0]          underrun_cnt_q, underrun_cnt_d;
  logic                 fall, right_evt, load_evt, bypass, pend_wr;

  assign s.s_ready    = !pend_full_q;
  assign aud_bclk     = bclk_q;
  assign aud_lrc      = lrc_q;
  assign dac_data     = dac_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

  // Divider, bit index, pair storage and dac_data update decisions.
  always_comb begin
    div_cnt_d      = div_cnt_q;
    bit_idx_d      = bit_idx_q;
    bclk_d         = bclk_q;
    lrc_d          = lrc_q;
    pend_full_d    = pend_full_q;
    pend_l_d       = pend_l_q;
    pend_r_d       = pend_r_q;
    cur_r_d        = cur_r_q;
    dac_d          = dac_q;
    underrun_d     = 1'b0;
    underrun_cnt_d = underrun_cnt_q;
    fall           = 1'b0;
    right_evt      = 1'b0;
    load_evt       = 1'b0;
    bypass         = 1'b0;
    pend_wr        = 1'b0;

    if (!en) begin
      div_cnt_d = '0;
      bit_idx_d = '0;
      bclk_d    = 1'b0;
      lrc_d     = 1'b0;
    end else begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        bclk_d    = ~bclk_q;
        fall      = bclk_q;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
      if (fall) begin
        bit_idx_d = (bit_idx_q == BIT_LAST) ? '0 : bit_idx_q + 1'b1;
        lrc_d     = (bit_idx_d >= SLOT_IDX);
        right_evt = (bit_idx_d == RIGHT_IDX);
        load_evt  = (bit_idx_d == LOAD_IDX);
      end
    end

    if (right_evt) begin
      dac_d = mute_word(cur_r_q, mute);
    end

    // The left word goes straight to dac_data at load; only the right word
    // needs to wait in the current register for its slot.
    if (load_evt) begin
      if (pend_full_q) begin
        cur_r_d     = pend_r_q;
        dac_d       = mute_word(pend_l_q, mute);
        pend_full_d = 1'b0;
      end else if (s.s_valid) begin
        cur_r_d = s.s_right;
        dac_d   = mute_word(s.s_left, mute);
        bypass  = 1'b1;
      end else begin
        cur_r_d        = '0;
        dac_d          = '0;
        underrun_d     = 1'b1;
        underrun_cnt_d = sat_inc16(underrun_cnt_q);
      end
    end

    // Accept only into an empty pending register; a bypassed pair skips it.
    if (s.s_valid && !pend_full_q && !bypass) begin
      pend_wr     = 1'b1;
      pend_full_d = 1'b1;
    end
    if (pend_wr) begin
      pend_l_d = s.s_left;
      pend_r_d = s.s_right;
    end
  end

  // Control state and staged output words; reset drops everything including a pending pair.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      div_cnt_q      <= '0;
      bit_idx_q      <= '0;
      bclk_q         <= 1'b0;
      lrc_q          <= 1'b0;
      pend_full_q    <= 1'b0;
      cur_r_q        <= '0;
      dac_q          <= '0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      bit_idx_q      <= bit_idx_d;
      bclk_q         <= bclk_d;
      lrc_q          <= lrc_d;
      pend_full_q    <= pend_full_d;
      cur_r_q        <= cur_r_d;
      dac_q          <= dac_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  // Pending sample data; meaningful only while pend_full_q is set.
  always_ff @(posedge sys_clk) begin
    pend_l_q <= pend_l_d;
    pend_r_q <= pend_r_d;
  end

endmodule

// File: tb/tb_aud_tx_sched.sv
// Directed bench for aud_tx_sched at default parameters: a source queue feeds
// the handshake, accepted pairs go to a scoreboard, and a cycle model derived
// from the frame timing checks every output after every clock edge.
module tb_aud_tx_sched;

  localparam int CLK_DIV   = 4;
  localparam int SLOT_BITS = 32;
  localparam int BCLK      = 2 * CLK_DIV;
  localparam int NBITS     = 2 * SLOT_BITS;
  localparam int FRAME     = NBITS * BCLK;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mute;
  logic        aud_bclk;
  logic        aud_lrc;
  logic [15:0] dac_data;
  logic        underrun;
  logic [15:0] underrun_cnt;

  aud_tx_sched_if #(.WL(16)) bus ();

  aud_tx_sched #(.CLK_DIV(CLK_DIV), .SLOT_BITS(SLOT_BITS), .WL(16)) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .en           (en),
    .mute         (mute),
    .s            (bus),
    .aud_bclk     (aud_bclk),
    .aud_lrc      (aud_lrc),
    .dac_data     (dac_data),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_asserts = 0;
  int          n_fail    = 0;
  int          cyc;
  pair_t       src[$];
  pair_t       sb[$];
  logic [15:0] cur_r;
  logic [15:0] exp_dac;
  logic [15:0] exp_cnt;
  logic        exp_under;

  function automatic pair_t mk(input logic [15:0] l, input logic [15:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive the handshake, advance the model on the edge, check all outputs.
  task automatic tick();
    logic  acc;
    pair_t p;
    int    idx;
    bus.s_valid = (src.size() > 0);
    if (src.size() > 0) begin
      bus.s_left  = src[0].l;
      bus.s_right = src[0].r;
    end
    acc = bus.s_valid && (sb.size() == 0);
    @(posedge sys_clk);
    if (acc) sb.push_back(src.pop_front());
    exp_under = 1'b0;
    if (en) cyc++;
    else cyc = 0;
    if (en && (cyc % BCLK == 0)) begin
      idx = (cyc / BCLK) % NBITS;
      if (idx == SLOT_BITS / 2) exp_dac = mute ? 16'h0 : cur_r;
      if (idx == SLOT_BITS + SLOT_BITS / 2) begin
        if (sb.size() > 0) begin
          p       = sb.pop_front();
          cur_r   = p.r;
          exp_dac = mute ? 16'h0 : p.l;
        end else begin
          cur_r     = 16'h0;
          exp_dac   = 16'h0;
          exp_under = 1'b1;
          exp_cnt   = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
        end
      end
    end
    @(negedge sys_clk);
    chk("bclk", 32'(aud_bclk), 32'((cyc / CLK_DIV) % 2));
    chk("lrc", 32'(aud_lrc), 32'(((cyc / BCLK) % NBITS) >= SLOT_BITS));
    chk("dac_data", 32'(dac_data), 32'(exp_dac));
    chk("underrun", 32'(underrun), 32'(exp_under));
    chk("underrun_cnt", 32'(underrun_cnt), 32'(exp_cnt));
    chk("s_ready", 32'(bus.s_ready), 32'(sb.size() == 0));
  endtask

  task automatic run_until(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; mute = 1'b0;
    bus.s_valid = 1'b0; bus.s_left = 16'h0; bus.s_right = 16'h0;
    cyc = 0; cur_r = 16'h0; exp_dac = 16'h0; exp_cnt = 16'h0; exp_under = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_bclk", 32'(aud_bclk), 32'd0);
    chk("rst_lrc", 32'(aud_lrc), 32'd0);
    chk("rst_dac", 32'(dac_data), 32'd0);
    chk("rst_under", 32'(underrun), 32'd0);
    chk("rst_cnt", 32'(underrun_cnt), 32'd0);
    chk("rst_ready", 32'(bus.s_ready), 32'd1);
    rst = 1'b0;
    repeat (4) tick();

    // Idle: an underrun every frame, first one 48 bclk periods after enable.
    en = 1'b1;
    run_until(383);
    chk("pre_first_underrun_cnt", 32'(underrun_cnt), 32'd0);
    tick();
    chk("first_underrun", 32'(underrun), 32'd1);
    chk("first_underrun_cnt", 32'(underrun_cnt), 32'd1);
    run_until(2 * FRAME);
    chk("idle_cnt_two_frames", 32'(underrun_cnt), 32'd2);

    // Two pairs with s_valid held; the second waits in front of a full pending register.
    src.push_back(mk(16'h1234, 16'hABCD));
    src.push_back(mk(16'h8000, 16'h7FFF));
    tick();
    chk("ready_low_when_pending", 32'(bus.s_ready), 32'd0);
    run_until(1410);
    chk("pair1_left", 32'(dac_data), 32'h1234);
    run_until(1700);
    chk("pair1_right", 32'(dac_data), 32'hABCD);
    run_until(1930);
    chk("pair2_left", 32'(dac_data), 32'h8000);
    run_until(2200);
    chk("pair2_right", 32'(dac_data), 32'h7FFF);

    // Bypass: s_valid first asserted on the load-event cycle with pending empty.
    run_until(2431);
    src.push_back(mk(16'h5A5A, 16'hC3C3));
    tick();
    chk("bypass_no_underrun", 32'(underrun), 32'd0);
    chk("bypass_ready", 32'(bus.s_ready), 32'd1);
    chk("bypass_left", 32'(dac_data), 32'h5A5A);
    chk("bypass_cnt", 32'(underrun_cnt), 32'd2);
    run_until(2700);
    chk("bypass_right", 32'(dac_data), 32'hC3C3);

    // Mute with continuous data: pairs still consumed, output zero, no underruns.
    mute = 1'b1;
    src.push_back(mk(16'h1111, 16'h2222));
    src.push_back(mk(16'h3333, 16'h4444));
    src.push_back(mk(16'h5555, 16'h6666));
    run_until(4236);
    chk("mute_dac", 32'(dac_data), 32'd0);
    chk("mute_cnt", 32'(underrun_cnt), 32'd2);
    mute = 1'b0;

    // Reset mid-frame with a pair sitting in pending.
    run_until(4500);
    chk("post_mute_underrun_cnt", 32'(underrun_cnt), 32'd3);
    src.push_back(mk(16'h7777, 16'h1111));
    tick();
    chk("pending_before_rst", 32'(bus.s_ready), 32'd0);
    rst = 1'b1; en = 1'b0; bus.s_valid = 1'b0;
    #1;
    sb.delete(); src.delete();
    cyc = 0; cur_r = 16'h0; exp_dac = 16'h0; exp_cnt = 16'h0; exp_under = 1'b0;
    chk("midrst_bclk", 32'(aud_bclk), 32'd0);
    chk("midrst_lrc", 32'(aud_lrc), 32'd0);
    chk("midrst_dac", 32'(dac_data), 32'd0);
    chk("midrst_cnt", 32'(underrun_cnt), 32'd0);
    chk("midrst_ready", 32'(bus.s_ready), 32'd1);
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    en  = 1'b1;
    run_until(400);
    chk("pending_lost_underrun_cnt", 32'(underrun_cnt), 32'd1);

    // en dropped mid-frame: clocks to 0, dac_data held, restart from bit 0.
    src.push_back(mk(16'h2468, 16'h1357));
    run_until(1200);
    chk("pre_disable_dac", 32'(dac_data), 32'h1357);
    en = 1'b0;
    repeat (10) tick();
    chk("disabled_dac_held", 32'(dac_data), 32'h1357);
    chk("disabled_bclk", 32'(aud_bclk), 32'd0);
    src.push_back(mk(16'h0F0F, 16'hF0F0));
    tick();
    chk("fill_while_disabled", 32'(bus.s_ready), 32'd0);
    en = 1'b1;
    run_until(400);
    chk("reenable_first_load", 32'(dac_data), 32'h0F0F);
    chk("reenable_cnt", 32'(underrun_cnt), 32'd1);

    // Saturation: preload the counter near full, then let underruns hit the top.
    run_until(900);
    chk("pre_force_cnt", 32'(underrun_cnt), 32'd2);
    force dut.underrun_cnt_d = 16'hFFFE;
    exp_cnt = 16'hFFFE;
    tick();
    release dut.underrun_cnt_d;
    tick();
    run_until(1408);
    chk("sat_reach_underrun", 32'(underrun), 32'd1);
    chk("sat_reach_cnt", 32'(underrun_cnt), 32'hFFFF);
    run_until(1920);
    chk("sat_hold_underrun", 32'(underrun), 32'd1);
    chk("sat_hold_cnt", 32'(underrun_cnt), 32'hFFFF);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
